ps2_key_tracker: RTL and testbench

Sequencing controller between the PS/2 byte receiver and game logic. Consumes validated scan-code bytes and tracks make/break/extended prefix sequences (E0, F0) with a state machine. Maintains independent held-key bitmaps for both players, so simultaneous key presses are reported. A stalled partial sequence is recovered by a watchdog.

---
 rtl/ps2_key_tracker.sv | 204 ++++++++++++++++++++
 tb/tb_ps2_key_tracker.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker.sv
// rtl/ps2_key_tracker.sv - PS/2 E0/F0 sequence tracker with per-player held-key bitmaps
// Optional typematic repeat suppression: define PS2_REPEAT_FILTER_EN.
module ps2_key_tracker #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    input  logic       rx_err,
    input  logic       clear_keys,
    output logic [4:0] p1keys,
    output logic [4:0] p2keys,
    output logic       key_event,
    output logic [8:0] event_code,
    output logic       event_break,
    output logic [7:0] debugLEDs,
    output logic       timeout_pulse
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } state_t;

    state_t          state_q, state_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [4:0]      p1_q, p1_d;
    logic [4:0]      p2_q, p2_d;
    logic            ev_q, ev_d;
    logic [8:0]      code_q, code_d;
    logic            brk_q, brk_d;
    logic [7:0]      led_q, led_d;
    logic            to_q, to_d;

    logic       is_e0, is_f0, is_ignored;
    logic       map_ext;
    logic [4:0] p1_mask, p2_mask;
    logic       done, done_ext, done_brk;
    logic       emit;

    assign is_e0 = (rx_byte == 8'hE0);
    assign is_f0 = (rx_byte == 8'hF0);
    assign is_ignored = (rx_byte == 8'hE1) || (rx_byte == 8'hFA) || (rx_byte == 8'hAA) ||
                        (rx_byte == 8'hFE) || (rx_byte == 8'hEE) || (rx_byte == 8'h00) ||
                        (rx_byte == 8'hFF);
    assign map_ext = (state_q == S_EXT) || (state_q == S_EXT_BRK);

    // Key lookup only matches when the extended flag agrees exactly.
    always_comb begin
        p1_mask = '0;
        p2_mask = '0;
        if (map_ext) begin
            case (rx_byte)
                8'h75:   p1_mask = 5'b00001;
                8'h6B:   p1_mask = 5'b00010;
                8'h74:   p1_mask = 5'b00100;
                8'h72:   p1_mask = 5'b01000;
                default: ;
            endcase
        end else begin
            case (rx_byte)
                8'h29:   p1_mask = 5'b10000;
                8'h1D:   p2_mask = 5'b00001;
                8'h1C:   p2_mask = 5'b00010;
                8'h23:   p2_mask = 5'b00100;
                8'h1B:   p2_mask = 5'b01000;
                8'h0D:   p2_mask = 5'b10000;
                default: ;
            endcase
        end
    end

`ifdef PS2_REPEAT_FILTER_EN
    logic already_set;
    assign already_set = |((p1_q & p1_mask) | (p2_q & p2_mask));
    assign emit = done_brk || !already_set;
`else
    assign emit = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        wd_d     = wd_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        ev_d     = 1'b0;
        code_d   = code_q;
        brk_d    = brk_q;
        led_d    = led_q;
        to_d     = 1'b0;
        done     = 1'b0;
        done_ext = 1'b0;
        done_brk = 1'b0;

        if (rx_err) begin
            state_d = S_IDLE;
            wd_d    = '0;
        end else if (rx_valid) begin
            led_d = rx_byte;
            wd_d  = '0;
            case (state_q)
                S_IDLE: begin
                    if (is_e0) begin
                        state_d = S_EXT;
                    end else if (is_f0) begin
                        state_d = S_BRK;
                    end else if (!is_ignored) begin
                        done = 1'b1;
                    end
                end
                S_EXT: begin
                    if (is_f0) begin
                        state_d = S_EXT_BRK;
                    end else if (!is_e0) begin
                        state_d  = S_IDLE;
                        done     = 1'b1;
                        done_ext = 1'b1;
                    end
                end
                S_BRK: begin
                    state_d  = S_IDLE;
                    done     = !(is_e0 || is_f0);
                    done_brk = 1'b1;
                end
                S_EXT_BRK: begin
                    state_d  = S_IDLE;
                    done     = !(is_e0 || is_f0);
                    done_ext = 1'b1;
                    done_brk = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                state_d = S_IDLE;
                wd_d    = '0;
                to_d    = 1'b1;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end else begin
            wd_d = '0;
        end

        // A same-cycle clear overrides the completing key entirely.
        if (done && ((p1_mask | p2_mask) != 5'b0) && !clear_keys) begin
            if (done_brk) begin
                p1_d = p1_q & ~p1_mask;
                p2_d = p2_q & ~p2_mask;
            end else begin
                p1_d = p1_q | p1_mask;
                p2_d = p2_q | p2_mask;
            end
            if (emit) begin
                ev_d   = 1'b1;
                code_d = {done_ext, rx_byte};
                brk_d  = done_brk;
            end
        end

        if (clear_keys) begin
            p1_d = '0;
            p2_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            wd_q    <= '0;
            p1_q    <= '0;
            p2_q    <= '0;
            ev_q    <= 1'b0;
            code_q  <= '0;
            brk_q   <= 1'b0;
            led_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            ev_q    <= ev_d;
            code_q  <= code_d;
            brk_q   <= brk_d;
            led_q   <= led_d;
            to_q    <= to_d;
        end
    end

    assign p1keys        = p1_q;
    assign p2keys        = p2_q;
    assign key_event     = ev_q;
    assign event_code    = code_q;
    assign event_break   = brk_q;
    assign debugLEDs     = led_q;
    assign timeout_pulse = to_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb/tb_ps2_key_tracker.sv - randomized and directed checks of ps2_key_tracker against a prefix-flag model
module tb_ps2_key_tracker;

    localparam int T = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;
    logic       clear_keys;
    logic [4:0] p1keys;
    logic [4:0] p2keys;
    logic       key_event;
    logic [8:0] event_code;
    logic       event_break;
    logic [7:0] debugLEDs;
    logic       timeout_pulse;

    ps2_key_tracker #(.TIMEOUT_CYCLES(T)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_byte       (rx_byte),
        .rx_valid      (rx_valid),
        .rx_err        (rx_err),
        .clear_keys    (clear_keys),
        .p1keys        (p1keys),
        .p2keys        (p2keys),
        .key_event     (key_event),
        .event_code    (event_code),
        .event_break   (event_break),
        .debugLEDs     (debugLEDs),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int ev_cnt = 0;

    bit         p_ext, p_brk;
    int         m_wd;
    logic [4:0] m_p1, m_p2;
    logic       m_ev, m_brk, m_to;
    logic [8:0] m_code;
    logic [7:0] m_led;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit ignored_byte(input logic [7:0] b);
        return b == 8'hE1 || b == 8'hFA || b == 8'hAA || b == 8'hFE ||
               b == 8'hEE || b == 8'h00 || b == 8'hFF;
    endfunction

    // Returns player*8 + bit index, or -1 for codes that map to nothing.
    function automatic int key_slot(input bit ext, input logic [7:0] b);
        if (ext) begin
            case (b)
                8'h75: return 0;
                8'h6B: return 1;
                8'h74: return 2;
                8'h72: return 3;
                default: return -1;
            endcase
        end
        case (b)
            8'h29: return 4;
            8'h1D: return 8;
            8'h1C: return 9;
            8'h23: return 10;
            8'h1B: return 11;
            8'h0D: return 12;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        p_ext = 0; p_brk = 0; m_wd = 0;
        m_p1 = '0; m_p2 = '0; m_ev = 0; m_brk = 0; m_to = 0;
        m_code = '0; m_led = '0;
    endtask

    task automatic model_step(input logic [7:0] b, input logic v, input logic e, input logic c);
        bit idle, fin, fext, fbrk, held;
        int slot;
        logic [4:0] msk;
        m_ev = 0; m_to = 0; fin = 0; fext = 0; fbrk = 0;
        idle = !p_ext && !p_brk;
        if (e) begin
            p_ext = 0; p_brk = 0; m_wd = 0;
        end else if (v) begin
            m_led = b; m_wd = 0;
            if (b == 8'hE0 || b == 8'hF0) begin
                if (p_brk) begin p_ext = 0; p_brk = 0; end
                else if (b == 8'hF0) p_brk = 1;
                else p_ext = 1;
            end else if (!(idle && ignored_byte(b))) begin
                fin = 1; fext = p_ext; fbrk = p_brk;
                p_ext = 0; p_brk = 0;
            end
        end else if (!idle) begin
            m_wd++;
            if (m_wd == T) begin
                p_ext = 0; p_brk = 0; m_wd = 0; m_to = 1;
            end
        end
        if (fin && !c) begin
            slot = key_slot(fext, b);
            if (slot >= 0) begin
                msk = 5'(1 << (slot % 8));
                held = (slot >= 8) ? ((m_p2 & msk) != 0) : ((m_p1 & msk) != 0);
                if (slot >= 8) m_p2 = fbrk ? (m_p2 & ~msk) : (m_p2 | msk);
                else           m_p1 = fbrk ? (m_p1 & ~msk) : (m_p1 | msk);
`ifdef PS2_REPEAT_FILTER_EN
                if (fbrk || !held) begin
`else
                if (1'b1 || held) begin
`endif
                    m_ev = 1; m_code = {fext, b}; m_brk = fbrk;
                end
            end
        end
        if (c) begin m_p1 = '0; m_p2 = '0; end
    endtask

    task automatic step(input logic [7:0] b, input logic v, input logic e, input logic c);
        rx_byte = b; rx_valid = v; rx_err = e; clear_keys = c;
        model_step(b, v, e, c);
        @(posedge clk);
        #1;
        check("p1keys", 32'(p1keys), 32'(m_p1));
        check("p2keys", 32'(p2keys), 32'(m_p2));
        check("key_event", 32'(key_event), 32'(m_ev));
        check("event_code", 32'(event_code), 32'(m_code));
        check("event_break", 32'(event_break), 32'(m_brk));
        check("debugLEDs", 32'(debugLEDs), 32'(m_led));
        check("timeout_pulse", 32'(timeout_pulse), 32'(m_to));
        if (key_event) ev_cnt++;
        rx_valid = 0; rx_err = 0; clear_keys = 0;
    endtask

    task automatic send(input logic [7:0] b);
        step(b, 1'b1, 1'b0, 1'b0);
    endtask

    function automatic logic [7:0] pick_byte();
        int r;
        r = $urandom_range(0, 19);
        case (r)
            0, 1: return 8'hE0;
            2, 3: return 8'hF0;
            4:  return 8'h75;
            5:  return 8'h6B;
            6:  return 8'h74;
            7:  return 8'h72;
            8:  return 8'h29;
            9:  return 8'h1D;
            10: return 8'h1C;
            11: return 8'h23;
            12: return 8'h1B;
            13: return 8'h0D;
            14: return 8'hAA;
            15: return 8'hE1;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        rx_byte = 8'h29; rx_valid = 1; rx_err = 0; clear_keys = 0; rst = 1;
        @(posedge clk); @(posedge clk);
        #1;
        rst = 0; rx_valid = 0;
        model_reset();
        check("rst_p1", 32'(p1keys), 32'h0);
        check("rst_p2", 32'(p2keys), 32'h0);
        check("rst_ev", 32'(key_event), 32'h0);
        check("rst_code", 32'(event_code), 32'h0);
        check("rst_leds", 32'(debugLEDs), 32'h0);
        check("rst_to", 32'(timeout_pulse), 32'h0);

        ev_cnt = 0;
        send(8'h1D); send(8'h23);
        check("wd_p2", 32'(p2keys), 32'h05);
        check("wd_events", 32'(ev_cnt), 32'd2);
        check("wd_code", 32'(event_code), 32'h023);
        check("wd_break", 32'(event_break), 32'h0);

        send(8'hE0); send(8'h75);
        check("up_make", 32'(p1keys), 32'h01);
        send(8'hE0); send(8'h6B);
        check("left_make", 32'(p1keys), 32'h03);
        send(8'hE0); send(8'hF0); send(8'h75);
        check("up_break", 32'(p1keys), 32'h02);
        check("up_break_code", 32'(event_code), 32'h175);
        check("up_break_flag", 32'(event_break), 32'h1);

        ev_cnt = 0;
        send(8'h75); send(8'hE0); send(8'h1D);
        check("flag_mismatch_ev", 32'(ev_cnt), 32'd0);
        check("flag_mismatch_p1", 32'(p1keys), 32'h02);
        check("flag_mismatch_p2", 32'(p2keys), 32'h05);
        check("flag_mismatch_leds", 32'(debugLEDs), 32'h1D);

        send(8'hE0);
        for (int i = 1; i <= T; i++) begin
            step(8'h00, 1'b0, 1'b0, 1'b0);
            check("watchdog_pulse", 32'(timeout_pulse), (i == T) ? 32'h1 : 32'h0);
        end
        send(8'h29);
        check("after_timeout_p1", 32'(p1keys), 32'h12);

        step(8'h00, 1'b0, 1'b0, 1'b1);
        check("clear_p1", 32'(p1keys), 32'h0);
        check("clear_p2", 32'(p2keys), 32'h0);
        send(8'hF0);
        step(8'h00, 1'b0, 1'b1, 1'b0);
        send(8'h1C);
        check("err_then_make", 32'(p2keys), 32'h02);
        ev_cnt = 0;
        step(8'h0D, 1'b1, 1'b0, 1'b1);
        check("clear_wins_p2", 32'(p2keys), 32'h0);
        check("clear_wins_ev", 32'(ev_cnt), 32'd0);
        send(8'hE0);
        step(8'h75, 1'b1, 1'b1, 1'b0);
        check("err_valid_leds", 32'(debugLEDs), 32'hE0);
        send(8'h75);
        check("err_valid_p1", 32'(p1keys), 32'h0);

        ev_cnt = 0;
        send(8'h29); send(8'h29); send(8'h29);
        check("repeat_p1", 32'(p1keys), 32'h10);
`ifdef PS2_REPEAT_FILTER_EN
        check("repeat_events", 32'(ev_cnt), 32'd1);
`else
        check("repeat_events", 32'(ev_cnt), 32'd3);
`endif

        for (int i = 0; i < 3000; i++) begin
            step(pick_byte(), $urandom_range(0, 1) == 1, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 29) == 0);
        end
        for (int i = 0; i < 3000; i++) begin
            step(pick_byte(), $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0,
                 $urandom_range(0, 99) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
